pulse_sync_sched: RTL and testbench

Source-domain scheduler that merges pulse events from several requesters onto one shared pulse-synchronizer channel. It runs entirely in the fast `clka` domain, in front of `sync_pulse`. It counts pending events per requester and picks among them round-robin. It issues single-cycle pulses on `pulse_out`, which feeds `sync_pulse.ina`, together with a requester ID. Issued pulses are spaced at least `GAP` cycles apart, so the slower destination domain never merges two pulses.

---
 rtl/pulse_sync_sched_if.sv | 24 ++
 rtl/pulse_sync_sched.sv | 115 +++++++++++
 tb/tb_pulse_sync_sched.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pulse_sync_sched_if.sv
// Handshake bundle between requesters and the pulse scheduler.
// The master side drives strobes and controls; the slave side issues pulses.
interface pulse_sync_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic             enable;
  logic [N_REQ-1:0] req_pulse;
  logic             ovf_clr;
  logic             pulse_out;
  logic [ID_W-1:0]  pulse_id;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] overflow;

  modport master (
    output enable, req_pulse, ovf_clr,
    input  pulse_out, pulse_id, pending, overflow
  );

  modport slave (
    input  enable, req_pulse, ovf_clr,
    output pulse_out, pulse_id, pending, overflow
  );
endinterface

// File: rtl/pulse_sync_sched.sv
// Round-robin scheduler merging requester events onto one pulse
// synchronizer channel, with a minimum GAP between issued pulses.
module pulse_sync_sched #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 3,
  parameter int GAP   = 8
) (
  input logic               clka,
  input logic               rsta,
  pulse_sync_sched_if.slave bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW   = (GAP > 2) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FIRE = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [1:0]       state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             pulse_q;
  logic [ID_W-1:0]  ptr_q, id_q;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  logic [N_REQ-1:0] ovf_q, ovf_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic             found, go;
  logic [ID_W-1:0]  win;
  int               idx;

  // Scan starts at the pointer; first nonzero counter wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && cnt_q[idx] != '0) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    go      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.enable && found) begin
          state_d = S_FIRE;
          go      = 1'b1;
        end
      end
      S_FIRE: begin
        state_d = S_HOLD;
        hold_d  = HW'(GAP - 3);
      end
      S_HOLD: begin
        if (hold_q == '0) state_d = S_IDLE;
        else              hold_d  = hold_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Same-edge grant and event cancel out, so no drop can occur then.
  always_comb begin
    ovf_d  = ovf_q;
    pend_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.ovf_clr) ovf_d[i] = 1'b0;
      if (bus.req_pulse[i] && !(go && win == ID_W'(i))) begin
        if (cnt_q[i] == CMAX) ovf_d[i] = 1'b1;
        else                  cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!bus.req_pulse[i] && go && win == ID_W'(i)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
      pend_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      pulse_q <= 1'b0;
      ptr_q   <= '0;
      id_q    <= '0;
      ovf_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pulse_q <= (state_d == S_FIRE);
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
      if (go) begin
        id_q  <= win;
        ptr_q <= (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.pulse_id  = id_q;
  assign bus.pending   = pend_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pulse_sync_sched.sv
// Randomized and directed bench for pulse_sync_sched against a
// time-based reference model (last issue time, counts, pointer).
module tb_pulse_sync_sched;
  localparam int N   = 4;
  localparam int GAP = 8;
  localparam int CM  = 7;

  logic clka = 1'b0;
  logic rsta = 1'b0;

  pulse_sync_sched_if #(.N_REQ(N), .ID_W(2)) bus ();

  pulse_sync_sched #(.N_REQ(N), .CNT_W(3), .GAP(GAP)) dut (
    .clka (clka),
    .rsta (rsta),
    .bus  (bus.slave)
  );

  always #5 clka = ~clka;

  int n_vec = 0;
  int n_err = 0;

  int       mcnt [N];
  int       mptr, mid, last_fire, ecnt;
  logic     mp;
  logic [N-1:0] movf;
  int       qid[$];
  int       qt[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] mpend();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = (mcnt[i] != 0);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    mptr = 0; mid = 0; mp = 1'b0; movf = '0;
    last_fire = -1000;
  endtask

  task automatic model_edge(input logic [N-1:0] rq, input logic en,
                            input logic clr);
    int w;
    bit any;
    any = 0;
    for (int i = 0; i < N; i++) if (mcnt[i] != 0) any = 1;
    mp = 1'b0;
    if (en && any && (ecnt - last_fire >= GAP)) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && mcnt[(mptr + k) % N] != 0) w = (mptr + k) % N;
      mcnt[w]--;
      mptr = (w + 1) % N;
      mid = w;
      mp = 1'b1;
      last_fire = ecnt;
    end
    if (clr) movf = '0;
    for (int i = 0; i < N; i++)
      if (rq[i]) begin
        if (mcnt[i] == CM) movf[i] = 1'b1;
        else mcnt[i]++;
      end
  endtask

  // Drive at negedge, model at posedge, check at next negedge.
  task automatic step(input logic [N-1:0] rq, input logic en,
                      input logic clr, input logic rst);
    bus.req_pulse = rq;
    bus.enable    = en;
    bus.ovf_clr   = clr;
    rsta          = rst;
    @(posedge clka);
    ecnt++;
    if (!rst) model_reset();
    else model_edge(rq, en, clr);
    @(negedge clka);
    chk("pulse", 32'(bus.pulse_out), 32'(mp));
    chk("id", 32'(bus.pulse_id), 32'(mid));
    chk("pend", 32'(bus.pending), 32'(mpend()));
    chk("ovf", 32'(bus.overflow), 32'(movf));
    if (bus.pulse_out) begin
      qid.push_back(int'(bus.pulse_id));
      qt.push_back(ecnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    int k;
    ecnt = 0;
    model_reset();
    bus.req_pulse = '0; bus.enable = 1'b0; bus.ovf_clr = 1'b0;
    @(negedge clka);
    for (int i = 0; i < 4; i++)
      step(4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    chk("rst_pulse", 32'(bus.pulse_out), 0);
    chk("rst_pend", 32'(bus.pending), 0);
    qid.delete(); qt.delete();
    idle(50);
    chk("quiet", 32'(qid.size()), 0);

    // Single event on requester 2
    qid.delete(); qt.delete();
    step(4'b0100, 1'b1, 1'b0, 1'b1);
    k = ecnt;
    idle(20);
    chk("single_n", 32'(qid.size()), 1);
    if (qid.size() == 1) begin
      chk("single_id", 32'(qid[0]), 2);
      chk("single_lat", 32'(qt[0]), 32'(k + 1));
    end

    // Simultaneous events: ptr is 3 now, realign via reset first
    step('0, 1'b1, 1'b0, 1'b0);
    qid.delete(); qt.delete();
    step(4'b1111, 1'b1, 1'b0, 1'b1);
    idle(40);
    chk("simul_n", 32'(qid.size()), 4);
    if (qid.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("simul_id", 32'(qid[i]), 32'(i));
        if (i > 0) chk("simul_gap", 32'(qt[i] - qt[i-1]), GAP);
      end

    // Fairness: requester 0 held, requester 3 once
    qid.delete(); qt.delete();
    step(4'b1001, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(4'b0001, 1'b1, 1'b0, 1'b1);
    k = 99;
    for (int i = qid.size() - 1; i >= 0; i--) if (qid[i] == 3) k = i;
    chk("fair", 32'(k < 4), 1);
    idle(80);

    // Burst on requester 1
    qid.delete(); qt.delete();
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b1, 1'b0, 1'b1);
    idle(40);
    chk("burst_n", 32'(qid.size()), 3);
    if (qid.size() == 3) begin
      chk("burst_id", 32'(qid[2]), 1);
      chk("burst_gap", 32'(qt[2] - qt[1]), GAP);
    end

    // Saturation with enable low, then drain
    qid.delete(); qt.delete();
    for (int i = 0; i < 10; i++) step(4'b0001, 1'b0, 1'b0, 1'b1);
    chk("sat_ovf", 32'(bus.overflow[0]), 1);
    chk("sat_quiet", 32'(qid.size()), 0);
    idle(80);
    chk("sat_drain", 32'(qid.size()), 7);
    step('0, 1'b1, 1'b1, 1'b1);
    chk("clr", 32'(bus.overflow), 0);
    for (int i = 0; i < 7; i++) step(4'b0001, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b1, 1'b1);
    chk("clr_vs_set", 32'(bus.overflow[0]), 1);
    idle(80);

    // Reset mid-HOLD with cnt[2] = 3
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step('0, 1'b1, 1'b0, 1'b1);
    #2 rsta = 1'b0;
    #1;
    model_reset();
    chk("arst_pulse", 32'(bus.pulse_out), 0);
    chk("arst_pend", 32'(bus.pending), 0);
    chk("arst_id", 32'(bus.pulse_id), 0);
    @(negedge clka);
    step('0, 1'b1, 1'b0, 1'b0);
    qid.delete(); qt.delete();
    idle(30);
    chk("arst_quiet", 32'(qid.size()), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] rq;
      rq = '0;
      for (int j = 0; j < N; j++) rq[j] = ($urandom_range(0, 9) == 0);
      step(rq, ($urandom_range(0, 7) != 0), ($urandom_range(0, 30) == 0),
           ($urandom_range(0, 400) != 0));
    end
    idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
